exec_unit: RTL and testbench
============================

# exec_unit

Execute stage of the OSECPU FPGA core, downstream of the fetch/sequencing controller. It consumes the controller's latched instruction word and state, captures the second instruction word during FETCH1, and holds the 64 x 32-bit integer register file R00–R3F. It performs integer ALU, compare and immediate-load operations with register writeback. Signed DIV/MOD runs on an iterative divider that stalls the controller in EXEC.

## Interface
- NREG, 64: number of integer registers; the index width is 6.
- DIV_STEPS, 32: number of iterative divider steps.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- current_state  in  4  controller state, encoded as `STATE_FETCH0/`STATE_FETCH1/`STATE_EXEC from def.v.
- instr0  in  32  current instruction: op[31:24], rd[23:18], rs1[17:12], rs2[11:6].
- memdata  in  32  instruction memory read data; the second instruction word is valid during FETCH1.
- stall  out  1  the controller holds EXEC and pc while this is 1.
- div_err  out  1  sticky divide-by-zero flag.
- dbg_addr  in  6  debug read index.
- dbg_data  out  32  combinational read R[dbg_addr].

## Operation
- Reset: all registers, instr1, the divider state, stall and div_err go to 0. dbg_data then reads 0.
- FETCH1: instr1 <= memdata. In all other states instr1 holds its value.
- EXEC executes op = instr0[31:24]. Operands are A = R[rs1] and B = R[rs2].
- Single-cycle ops write R[rd] at the end of the (only) EXEC cycle:
  - 0x10 OR, 0x11 XOR, 0x12 AND.
  - 0x14 ADD, 0x15 SUB: mod 2^32.
  - 0x16 MUL: low 32 bits of the product.
  - 0x18 SHL: A << B[4:0].
  - 0x19 SAR: arithmetic A >>> B[4:0].
  - 0xD0 LIMM: R[rd] <= instr1.
- Compares are signed and write 0xFFFFFFFF when true, 0 when false:
  - 0x20 EQ, 0x21 NE, 0x22 LT, 0x23 GE, 0x24 LE, 0x25 GT, each comparing A against B.
- 0x1A DIV and 0x1B MOD are signed.
  - The quotient truncates toward zero.
  - The remainder takes the sign of A.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- Any other op, including `OP_HLT and 0x01, writes no register.
- rd == rs1 or rd == rs2 is legal: operands are read before the write.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on the first EXEC cycle of DIV/MOD with B != 0. This cycle latches |A|, |B|, both signs and count = DIV_STEPS.
  - RUN: one restoring shift-subtract step per cycle, count decrements. RUN→DONE when count reaches 1 (after the last step).
  - DONE: sign-correct the result, write R[rd] at the end of the cycle, →IDLE.
- Divide by zero (B == 0): no stall. R[rd] <= 0 at the end of the first EXEC cycle, div_err <= 1.
  - div_err clears only on reset.
- stall is combinational: EXEC && (op is DIV/MOD) && B != 0 && divider not in DONE.

## Timing
- Single-cycle ops: EXEC lasts 1 cycle. The write is visible on dbg_data in the next cycle.
- LIMM: instr1 is captured at the FETCH1 edge and written at the EXEC edge.
- DIV/MOD with B != 0: EXEC lasts DIV_STEPS + 2 = 34 cycles.
  - stall = 1 for E0..E32 and 0 in E33.
  - The result is written at the E33 edge, on the same edge the controller leaves EXEC.
- dbg_data on the same cycle as a write shows the old value.
- Reset asserted mid-divide: the operation aborts with no write. The divider returns to IDLE and stall is 0 from the next cycle.
- The block writes no registers outside EXEC, including while the controller is halted.

## Test plan
- Reset → dbg_data 0 for dbg_addr 0x00 and 0x3F; stall = 0, div_err = 0.
- LIMM R01 = 0x0000000C, LIMM R02 = 0xFFFFFFFB (-5), then ADD R03 = R01 + R02 → R03 = 7. SUB R04 = R02 - R01 → 0xFFFFFFEF.
- With R02 = -5:
  - SAR R05 = R02 >>> 1 → 0xFFFFFFFD.
  - SHL by B = 33 uses amount 1.
  - CMPLT R02 < R01 → 0xFFFFFFFF; CMPGT → 0.
- DIV -7 / 2 → 0xFFFFFFFD; MOD -7 / 2 → 0xFFFFFFFF.
  - stall is high for exactly 33 cycles and the write lands on the 34th EXEC edge.
  - 0x80000000 / -1 → 0x80000000.
- DIV by R00 = 0 → rd = 0, div_err = 1, no stall cycle. A following ADD still executes and div_err stays 1.
- Assert reset at E10 of a DIV → rd unchanged, stall = 0 next cycle, all registers 0 after reset.

Source files
------------

// File: rtl/exec_unit.sv
// ============================================================================
// exec_unit
// Execute stage: register file, single-cycle ALU/compare/LIMM, and an
// iterative signed divider that stalls the controller in EXEC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_unit #(
  parameter int         NREG         = 64,
  parameter int         DIV_STEPS    = 32,
  parameter logic [3:0] STATE_FETCH1 = 4'd1,
  parameter logic [3:0] STATE_EXEC   = 4'd2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              current_state,
  input  logic [31:0]             instr0,
  input  logic [31:0]             memdata,
  output logic                    stall,
  output logic                    div_err,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [31:0]             dbg_data
);

  localparam int IDX_W = $clog2(NREG);
  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_DONE = 2'd2} div_state_t;

  logic [31:0]      regs_q [NREG];
  logic [31:0]      regs_d [NREG];
  logic [31:0]      instr1_q, instr1_d;
  div_state_t       div_state_q, div_state_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_err_q, div_err_d;

  logic [7:0]       op;
  logic [IDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [31:0]      opa, opb;
  logic             in_exec, is_div;
  logic             we;
  logic [31:0]      wdata;
  logic [32:0]      shifted, trial;
  logic             unused_instr_bits;

  assign op                = instr0[31:24];
  assign rd_idx            = instr0[18 +: IDX_W];
  assign rs1_idx           = instr0[12 +: IDX_W];
  assign rs2_idx           = instr0[6 +: IDX_W];
  assign unused_instr_bits = ^instr0[5:0];
  assign opa               = regs_q[rs1_idx];
  assign opb               = regs_q[rs2_idx];
  assign in_exec           = (current_state == STATE_EXEC);
  assign is_div            = (op == 8'h1A) || (op == 8'h1B);
  assign shifted           = {rem_q, quo_q[31]};
  assign trial             = shifted - {1'b0, dvs_q};

  assign stall    = in_exec && is_div && (opb != 32'd0) && (div_state_q != DIV_DONE);
  assign div_err  = div_err_q;
  assign dbg_data = regs_q[dbg_addr];

  always_comb begin
    div_state_d = div_state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    cnt_d       = cnt_q;
    div_err_d   = div_err_q;
    instr1_d    = (current_state == STATE_FETCH1) ? memdata : instr1_q;
    we          = 1'b0;
    wdata       = 32'd0;

    // Divider sequencing: latch magnitudes, restoring steps, then sign fix-up
    case (div_state_q)
      DIV_IDLE: begin
        if (in_exec && is_div && (opb != 32'd0)) begin
          div_state_d = DIV_RUN;
          quo_d       = opa[31] ? -opa : opa;
          dvs_d       = opb[31] ? -opb : opb;
          rem_d       = 32'd0;
          neg_quo_d   = opa[31] ^ opb[31];
          neg_rem_d   = opa[31];
          cnt_d       = CNT_W'(DIV_STEPS);
        end
      end
      DIV_RUN: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          div_state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        div_state_d = DIV_IDLE;
      end
      default: begin
        div_state_d = DIV_IDLE;
      end
    endcase

    if (in_exec) begin
      if (is_div) begin
        if (opb == 32'd0) begin
          we        = 1'b1;
          div_err_d = 1'b1;
        end else if (div_state_q == DIV_DONE) begin
          we    = 1'b1;
          wdata = (op == 8'h1B) ? (neg_rem_q ? -rem_q : rem_q)
                                : (neg_quo_q ? -quo_q : quo_q);
        end
      end else begin
        we = 1'b1;
        case (op)
          8'h10:   wdata = opa | opb;
          8'h11:   wdata = opa ^ opb;
          8'h12:   wdata = opa & opb;
          8'h14:   wdata = opa + opb;
          8'h15:   wdata = opa - opb;
          8'h16:   wdata = opa * opb;
          8'h18:   wdata = opa << opb[4:0];
          8'h19:   wdata = $unsigned($signed(opa) >>> opb[4:0]);
          8'h20:   wdata = {32{opa == opb}};
          8'h21:   wdata = {32{opa != opb}};
          8'h22:   wdata = {32{$signed(opa) <  $signed(opb)}};
          8'h23:   wdata = {32{$signed(opa) >= $signed(opb)}};
          8'h24:   wdata = {32{$signed(opa) <= $signed(opb)}};
          8'h25:   wdata = {32{$signed(opa) >  $signed(opb)}};
          8'hD0:   wdata = instr1_q;
          default: we    = 1'b0;
        endcase
      end
    end

    regs_d = regs_q;
    if (we) begin
      regs_d[rd_idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 32'd0;
      end
      instr1_q    <= 32'd0;
      div_state_q <= DIV_IDLE;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= '0;
      div_err_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      instr1_q    <= instr1_d;
      div_state_q <= div_state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      cnt_q       <= cnt_d;
      div_err_q   <= div_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
// tb_exec_unit
// Drives a controller-like FETCH0/FETCH1/EXEC sequence and checks against a
// behavioural register-file model every cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_unit;

  localparam logic [3:0] ST_F0   = 4'd0;
  localparam logic [3:0] ST_F1   = 4'd1;
  localparam logic [3:0] ST_EXEC = 4'd2;
  localparam logic [3:0] ST_HALT = 4'd15;
  localparam int         STEPS   = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  current_state = ST_F0;
  logic [31:0] instr0 = 32'd0;
  logic [31:0] memdata = 32'd0;
  logic        stall;
  logic        div_err;
  logic [5:0]  dbg_addr = 6'd0;
  logic [31:0] dbg_data;

  logic [31:0] m_reg [64];
  logic        m_err = 1'b0;
  logic        exp_stall = 1'b0;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  exec_unit #(.NREG(64), .DIV_STEPS(STEPS), .STATE_FETCH1(ST_F1), .STATE_EXEC(ST_EXEC)) dut (
    .clk(clk), .reset(reset), .current_state(current_state), .instr0(instr0),
    .memdata(memdata), .stall(stall), .div_err(div_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("div_err", {31'd0, div_err}, {31'd0, m_err});
      chk("dbg_data", dbg_data, m_reg[dbg_addr]);
    end
  end

  // Reference semantics: returns {write_enable, value}
  function automatic logic [32:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    case (op)
      8'h10: return {1'b1, a | b};
      8'h11: return {1'b1, a ^ b};
      8'h12: return {1'b1, a & b};
      8'h14: return {1'b1, a + b};
      8'h15: return {1'b1, a - b};
      8'h16: return {1'b1, 32'(a * b)};
      8'h18: return {1'b1, 32'(a << b[4:0])};
      8'h19: begin sr = sa >>> b[4:0]; return {1'b1, sr}; end
      8'h20: return {1'b1, (sa == sb) ? 32'hFFFFFFFF : 32'd0};
      8'h21: return {1'b1, (sa != sb) ? 32'hFFFFFFFF : 32'd0};
      8'h22: return {1'b1, (sa <  sb) ? 32'hFFFFFFFF : 32'd0};
      8'h23: return {1'b1, (sa >= sb) ? 32'hFFFFFFFF : 32'd0};
      8'h24: return {1'b1, (sa <= sb) ? 32'hFFFFFFFF : 32'd0};
      8'h25: return {1'b1, (sa >  sb) ? 32'hFFFFFFFF : 32'd0};
      8'hD0: return {1'b1, imm};
      8'h1A, 8'h1B: begin
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {1'b1, (op == 8'h1A) ? 32'h80000000 : 32'd0};
        sr = (op == 8'h1A) ? (sa / sb) : (sa % sb);
        return {1'b1, sr};
      end
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    dbg_addr = 6'($urandom);
  endtask

  task automatic check_lit(input string nm, input logic [5:0] addr, input logic [31:0] val);
    dbg_addr = addr;
    #1;
    chk(nm, dbg_data, val);
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [5:0] rd, input logic [5:0] rs1,
                           input logic [5:0] rs2, input logic [31:0] imm, input int abort_at);
    logic [31:0] a, b;
    logic [32:0] res;
    current_state = ST_F0;
    instr0        = {op, rd, rs1, rs2, 6'($urandom)};
    memdata       = $urandom;
    exp_stall     = 1'b0;
    cycle();
    current_state = ST_F1;
    memdata       = imm;
    cycle();
    memdata       = $urandom;
    current_state = ST_EXEC;
    a   = m_reg[rs1];
    b   = m_reg[rs2];
    res = model(op, a, b, imm);
    if ((op == 8'h1A || op == 8'h1B) && b != 32'd0) begin
      for (int k = 0; k <= STEPS + 1; k++) begin
        exp_stall = (k <= STEPS);
        if (k == abort_at) reset = 1'b1;
        cycle();
        if (k == abort_at) begin
          reset = 1'b0;
          for (int i = 0; i < 64; i++) m_reg[i] = 32'd0;
          m_err         = 1'b0;
          exp_stall     = 1'b0;
          current_state = ST_F0;
          return;
        end
      end
      exp_stall = 1'b0;
    end else begin
      cycle();
      if (op == 8'h1A || op == 8'h1B) m_err = 1'b1;
    end
    if (res[32]) m_reg[rd] = res[31:0];
    current_state = ST_F0;
  endtask

  task automatic limm(input logic [5:0] rd, input logic [31:0] v);
    run_instr(8'hD0, rd, 6'($urandom), 6'($urandom), v, -1);
  endtask

  logic [7:0] op_tab [20];

  initial begin
    for (int i = 0; i < 64; i++) m_reg[i] = 32'd0;
    op_tab = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16, 8'h18, 8'h19, 8'h20, 8'h21,
               8'h22, 8'h23, 8'h24, 8'h25, 8'hD0, 8'h1A, 8'h1B, 8'h00, 8'h01, 8'hFF};
    cycle();
    cycle();
    reset  = 1'b0;
    chk_en = 1'b1;
    check_lit("reset_r00", 6'h00, 32'd0);
    check_lit("reset_r3f", 6'h3F, 32'd0);

    limm(6'h01, 32'h0000000C);
    limm(6'h02, 32'hFFFFFFFB);
    run_instr(8'h14, 6'h03, 6'h01, 6'h02, 32'd0, -1);
    check_lit("add", 6'h03, 32'h00000007);
    run_instr(8'h15, 6'h04, 6'h02, 6'h01, 32'd0, -1);
    check_lit("sub", 6'h04, 32'hFFFFFFEF);
    limm(6'h06, 32'd1);
    run_instr(8'h19, 6'h05, 6'h02, 6'h06, 32'd0, -1);
    check_lit("sar", 6'h05, 32'hFFFFFFFD);
    limm(6'h07, 32'd33);
    run_instr(8'h18, 6'h08, 6'h02, 6'h07, 32'd0, -1);
    check_lit("shl33", 6'h08, 32'hFFFFFFF6);
    run_instr(8'h22, 6'h09, 6'h02, 6'h01, 32'd0, -1);
    check_lit("cmplt", 6'h09, 32'hFFFFFFFF);
    run_instr(8'h25, 6'h0A, 6'h02, 6'h01, 32'd0, -1);
    check_lit("cmpgt", 6'h0A, 32'h00000000);
    limm(6'h0B, 32'hFFFFFFF9);
    limm(6'h0C, 32'd2);
    run_instr(8'h1A, 6'h0D, 6'h0B, 6'h0C, 32'd0, -1);
    check_lit("div", 6'h0D, 32'hFFFFFFFD);
    run_instr(8'h1B, 6'h0E, 6'h0B, 6'h0C, 32'd0, -1);
    check_lit("mod", 6'h0E, 32'hFFFFFFFF);
    limm(6'h10, 32'h80000000);
    limm(6'h11, 32'hFFFFFFFF);
    run_instr(8'h1A, 6'h12, 6'h10, 6'h11, 32'd0, -1);
    check_lit("div_ovf", 6'h12, 32'h80000000);
    limm(6'h14, 32'd5);
    run_instr(8'h1A, 6'h14, 6'h01, 6'h00, 32'd0, -1);
    check_lit("div0_rd", 6'h14, 32'd0);
    chk("div0_err", {31'd0, div_err}, 32'd1);
    run_instr(8'h14, 6'h15, 6'h01, 6'h01, 32'd0, -1);
    check_lit("add_after_div0", 6'h15, 32'h00000018);

    for (int i = 1; i < 64; i++) limm(6'(i), (i % 7 == 0) ? 32'd0 : $urandom);
    for (int n = 0; n < 300; n++) begin
      int unsigned idx;
      logic [7:0]  op;
      idx = $urandom_range(0, 20);
      op  = (idx == 20) ? 8'($urandom) : op_tab[idx];
      if (n % 25 == 0) begin
        current_state = ST_HALT;
        instr0        = {8'hD0, 24'($urandom)};
        repeat (3) cycle();
      end
      run_instr(op, 6'($urandom), 6'($urandom), 6'($urandom), $urandom, -1);
    end

    limm(6'h20, 32'd100);
    limm(6'h21, 32'd3);
    limm(6'h22, 32'h55);
    run_instr(8'h1A, 6'h22, 6'h20, 6'h21, 32'd0, 10);
    check_lit("abort_rd", 6'h22, 32'd0);
    check_lit("abort_r20", 6'h20, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    limm(6'h01, 32'd40);
    run_instr(8'h1B, 6'h02, 6'h01, 6'h06, 32'd0, -1);
    check_lit("div0_after_reset", 6'h02, 32'd0);
    cycle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
